// File: rtl/lmc_loader_pkg.sv
// rtl/lmc_loader_pkg.sv - shared loader FSM states and LMC instruction field positions
// Package lmc_pkg
//   lmc_state_t : loader FSM state encoding
//   LMC_*       : bit positions of the LMC instruction fields held in program memory
package lmc_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_WRITE = 3'd2,
        ST_CHECK = 3'd3,
        ST_DONE  = 3'd4,
        ST_RUN   = 3'd5
    } lmc_state_t;

    // LMC instruction word layout
    localparam int unsigned LMC_BIT_JUMP     = 7;
    localparam int unsigned LMC_BIT_ACC_LOAD = 6;
    localparam int unsigned LMC_BIT_MUX_SEL  = 5;
    localparam int unsigned LMC_JMP_TGT_MSB  = 1;
    localparam int unsigned LMC_JMP_TGT_LSB  = 0;

endpackage

// File: rtl/lmc_loader_if.sv
// rtl/lmc_loader_if.sv - host byte stream, program memory bus and CPU control bundle
// Interface lmc_loader_if #(ADDR_WIDTH, DATA_WIDTH)
//   load_start            : host request to (re)load program memory
//   in_data/in_valid/in_ready : host byte handshake
//   mem_adr/mem_data/mem_we   : program memory write port (mem_adr also drives readback)
//   mem_rdata             : program memory combinational read data
//   cpu_run/load_done/load_error : CPU enable and load status
// Modports: slave = loader side, master = host / memory / CPU side.
interface lmc_loader_if #(
    parameter int ADDR_WIDTH = 2,
    parameter int DATA_WIDTH = 8
);
    logic                  load_start;
    logic [DATA_WIDTH-1:0] in_data;
    logic                  in_valid;
    logic                  in_ready;
    logic [ADDR_WIDTH-1:0] mem_adr;
    logic [DATA_WIDTH-1:0] mem_data;
    logic                  mem_we;
    logic [DATA_WIDTH-1:0] mem_rdata;
    logic                  cpu_run;
    logic                  load_done;
    logic                  load_error;

    modport slave (
        input  load_start, in_data, in_valid, mem_rdata,
        output in_ready, mem_adr, mem_data, mem_we, cpu_run, load_done, load_error
    );

    modport master (
        output load_start, in_data, in_valid, mem_rdata,
        input  in_ready, mem_adr, mem_data, mem_we, cpu_run, load_done, load_error
    );

endinterface

// File: rtl/lmc_addr_counter.sv
// rtl/lmc_addr_counter.sv - program memory address counter with clear and increment
// Ports
//   clk, rst  : clock, asynchronous active-high reset
//   i_clr     : synchronous clear to 0 (wins over i_inc)
//   i_inc     : advance by one, ADDR_WIDTH-bit wrap
//   o_addr    : current address
module lmc_addr_counter #(
    parameter int ADDR_WIDTH = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_clr,
    input  logic                  i_inc,
    output logic [ADDR_WIDTH-1:0] o_addr
);

    logic [ADDR_WIDTH-1:0] r_addr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_addr <= '0;
        end else if (i_clr) begin
            r_addr <= '0;
        end else if (i_inc) begin
            r_addr <= r_addr + ADDR_WIDTH'(1);
        end
    end

    assign o_addr = r_addr;

endmodule

// File: rtl/lmc_loader.sv
// rtl/lmc_loader.sv - loads host bytes into LMC program memory, then releases the CPU
// Ports
//   timer555    : clock, all state on its rising edge
//   reset_count : asynchronous active-high reset
//   bus         : lmc_loader_if.slave (host stream, memory port, CPU control)
// Optional feature macro: LMC_LOADER_READBACK_EN (XOR readback verify after the last write)
module lmc_loader
    import lmc_pkg::*;
#(
    parameter int ADDR_WIDTH = 2,
    parameter int DATA_WIDTH = 8
) (
    input  logic        timer555,
    input  logic        reset_count,
    lmc_loader_if.slave bus
);

    lmc_state_t            r_state;
    lmc_state_t            w_state_nxt;
    logic [ADDR_WIDTH-1:0] w_addr;
    logic [DATA_WIDTH-1:0] r_mem_data;
    logic                  w_last;
    logic                  w_accept;
    logic                  w_start;
    logic                  w_addr_clr;
    logic                  w_addr_inc;
    logic                  w_in_ready;
    logic                  w_mem_we;
    logic                  w_cpu_run;
    logic                  w_load_done;

    // Only a full-depth load ever ends, so the last word is the all-ones address.
    assign w_last   = (w_addr == {ADDR_WIDTH{1'b1}});
    assign w_accept = (r_state == ST_LOAD) && bus.in_valid;
    // load_start is only honoured while the CPU side is quiescent.
    assign w_start  = bus.load_start && ((r_state == ST_IDLE) || (r_state == ST_RUN));

    lmc_addr_counter #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_addr_counter (
        .clk    (timer555),
        .rst    (reset_count),
        .i_clr  (w_addr_clr),
        .i_inc  (w_addr_inc),
        .o_addr (w_addr)
    );

    always_ff @(posedge timer555 or posedge reset_count) begin
        if (reset_count) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE, ST_RUN: begin
                if (bus.load_start) begin
                    w_state_nxt = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (bus.in_valid) begin
                    w_state_nxt = ST_WRITE;
                end
            end
            ST_WRITE: begin
                if (w_last) begin
`ifdef LMC_LOADER_READBACK_EN
                    w_state_nxt = ST_CHECK;
`else
                    w_state_nxt = ST_DONE;
`endif
                end else begin
                    w_state_nxt = ST_LOAD;
                end
            end
`ifdef LMC_LOADER_READBACK_EN
            ST_CHECK: begin
                if (w_last) begin
                    w_state_nxt = ST_DONE;
                end
            end
`endif
            ST_DONE: begin
                w_state_nxt = ST_RUN;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        w_in_ready  = 1'b0;
        w_mem_we    = 1'b0;
        w_cpu_run   = 1'b0;
        w_load_done = 1'b0;
        w_addr_clr  = 1'b0;
        w_addr_inc  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_addr_clr = bus.load_start;
            end
            ST_LOAD: begin
                w_in_ready = 1'b1;
            end
            ST_WRITE: begin
                w_mem_we   = 1'b1;
                w_addr_clr = w_last;
                w_addr_inc = !w_last;
            end
`ifdef LMC_LOADER_READBACK_EN
            ST_CHECK: begin
                w_addr_clr = w_last;
                w_addr_inc = !w_last;
            end
`endif
            ST_DONE: begin
                w_load_done = 1'b1;
            end
            ST_RUN: begin
                w_cpu_run  = 1'b1;
                w_addr_clr = bus.load_start;
            end
            default: begin
            end
        endcase
    end

    // Byte is held here through the WRITE cycle so mem_data is stable under mem_we.
    always_ff @(posedge timer555 or posedge reset_count) begin
        if (reset_count) begin
            r_mem_data <= '0;
        end else if (w_accept) begin
            r_mem_data <= bus.in_data;
        end
    end

`ifdef LMC_LOADER_READBACK_EN
    logic [DATA_WIDTH-1:0] r_checksum;
    logic [DATA_WIDTH-1:0] r_rd_sum;
    logic                  r_load_error;
    logic [DATA_WIDTH-1:0] w_rd_sum_nxt;

    assign w_rd_sum_nxt = r_rd_sum ^ bus.mem_rdata;

    always_ff @(posedge timer555 or posedge reset_count) begin
        if (reset_count) begin
            r_checksum   <= '0;
            r_rd_sum     <= '0;
            r_load_error <= 1'b0;
        end else if (w_start) begin
            r_checksum   <= '0;
            r_rd_sum     <= '0;
            r_load_error <= 1'b0;
        end else begin
            if (w_accept) begin
                r_checksum <= r_checksum ^ bus.in_data;
            end
            if (r_state == ST_CHECK) begin
                r_rd_sum <= w_rd_sum_nxt;
                // Compare includes the last word read this cycle, so the flag is
                // already valid in the DONE cycle alongside load_done.
                if (w_last && (w_rd_sum_nxt != r_checksum)) begin
                    r_load_error <= 1'b1;
                end
            end
        end
    end

    assign bus.load_error = r_load_error;
`else
    logic unused_rdata;
    assign unused_rdata   = ^bus.mem_rdata;
    assign bus.load_error = 1'b0;
`endif

    assign bus.in_ready  = w_in_ready;
    assign bus.mem_we    = w_mem_we;
    assign bus.cpu_run   = w_cpu_run;
    assign bus.load_done = w_load_done;
    assign bus.mem_adr   = w_addr;
    assign bus.mem_data  = r_mem_data;

endmodule
